// File: rtl/ika87ad_mcseq_if.sv
// Microcode ROM and bus handshake between the IKA87AD sequencer (master) and its ROM/bus unit (slave).
// Signal names carry their direction as seen from the sequencer.
interface ika87ad_mcseq_if #(
  parameter int ADDR_W = 8
);
  logic              o_MCROM_READ_TICK;
  logic [ADDR_W-1:0] o_MCROM_ADDR;
  logic [17:0]       i_MCROM_DATA;
  logic              o_BUS_REQ;
  logic [1:0]        o_BUS_TYPE;
  logic              i_BUS_DONE;

  modport master (
    output o_MCROM_READ_TICK,
    output o_MCROM_ADDR,
    input  i_MCROM_DATA,
    output o_BUS_REQ,
    output o_BUS_TYPE,
    input  i_BUS_DONE
  );

  modport slave (
    input  o_MCROM_READ_TICK,
    input  o_MCROM_ADDR,
    output i_MCROM_DATA,
    input  o_BUS_REQ,
    input  o_BUS_TYPE,
    output i_BUS_DONE
  );
endinterface

// File: rtl/ika87ad_mcseq.sv
// IKA87AD microcode sequencer: fetches an opcode, walks its microsteps through the ROM and
// issues one bus cycle per step; halt and fault handling happen at instruction boundaries.
module ika87ad_mcseq #(
  parameter int  MAX_STEPS = 8,
  parameter int  ADDR_W    = 8,
  localparam int STEP_W    = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_CEN,
  input  logic [ADDR_W-1:0]  i_ENTRY_ADDR,
  ika87ad_mcseq_if.master    mc,
  output logic               o_MC_EXEC,
  output logic [STEP_W-1:0]  o_STEP,
  output logic               o_INSTR_DONE,
  input  logic               i_HALT,
  output logic               o_HALTED,
  output logic               o_FAULT
);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_FETCH = 3'd1,
    ST_TICK  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_BUS   = 3'd4,
    ST_HALT  = 3'd5
  } state_e;

  localparam logic [1:0]        BT_RD4    = 2'b00;
  localparam logic [2:0]        CODE_RD4  = 3'd0;
  localparam logic [2:0]        CODE_INT  = 3'd3;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  function automatic logic is_reserved(input logic [2:0] code);
    return code[2];
  endfunction

  function automatic logic ends_instr(input logic [2:0] code);
    return (code == CODE_RD4) || is_reserved(code);
  endfunction

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [STEP_W-1:0]   step_q;
  logic                bus_req_q;
  logic [1:0]          bus_type_q;
  logic                tick_q;
  logic                exec_q;
  logic                instr_done_q;
  logic                halted_q;
  logic                fault_q;

  logic [2:0]          code_s;
  logic                last_step_s;
  logic                end_s;
  logic                fault_end_s;
  logic                unused_data_s;

  assign code_s        = mc.i_MCROM_DATA[2:0];
  assign last_step_s   = (step_q == LAST_STEP);
  // A step-limit abort ends the instruction exactly like RD4 but also flags a fault.
  assign end_s         = ends_instr(code_s) || last_step_s;
  assign fault_end_s   = is_reserved(code_s) || (!ends_instr(code_s) && last_step_s);
  assign unused_data_s = ^mc.i_MCROM_DATA[17:3];

  // Sequencer state machine with all outputs held in registers.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q      <= ST_RST;
      addr_q       <= {ADDR_W{1'b0}};
      step_q       <= {STEP_W{1'b0}};
      bus_req_q    <= 1'b0;
      bus_type_q   <= BT_RD4;
      tick_q       <= 1'b0;
      exec_q       <= 1'b0;
      instr_done_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else if (i_CEN) begin
      case (state_q)
        ST_RST: begin
          state_q    <= ST_FETCH;
          bus_req_q  <= 1'b1;
          bus_type_q <= BT_RD4;
        end
        ST_FETCH: begin
          if (mc.i_BUS_DONE) begin
            addr_q       <= i_ENTRY_ADDR;
            step_q       <= {STEP_W{1'b0}};
            bus_req_q    <= 1'b0;
            instr_done_q <= 1'b1;
            tick_q       <= 1'b1;
            state_q      <= ST_TICK;
          end
        end
        ST_TICK: begin
          tick_q       <= 1'b0;
          instr_done_q <= 1'b0;
          exec_q       <= 1'b1;
          state_q      <= ST_EXEC;
        end
        ST_EXEC: begin
          exec_q <= 1'b0;
          if (end_s) begin
            if (fault_end_s) begin
              fault_q <= 1'b1;
            end
            if (i_HALT) begin
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end else begin
              bus_req_q  <= 1'b1;
              bus_type_q <= BT_RD4;
              state_q    <= ST_FETCH;
            end
          end else if (code_s == CODE_INT) begin
            addr_q  <= addr_q + ADDR_W'(1'b1);
            step_q  <= step_q + STEP_W'(1'b1);
            tick_q  <= 1'b1;
            state_q <= ST_TICK;
          end else begin
            bus_req_q  <= 1'b1;
            bus_type_q <= code_s[1:0];
            state_q    <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (mc.i_BUS_DONE) begin
            bus_req_q <= 1'b0;
            addr_q    <= addr_q + ADDR_W'(1'b1);
            step_q    <= step_q + STEP_W'(1'b1);
            tick_q    <= 1'b1;
            state_q   <= ST_TICK;
          end
        end
        ST_HALT: begin
          if (!i_HALT) begin
            halted_q   <= 1'b0;
            bus_req_q  <= 1'b1;
            bus_type_q <= BT_RD4;
            state_q    <= ST_FETCH;
          end
        end
        default: begin
          bus_req_q    <= 1'b0;
          tick_q       <= 1'b0;
          exec_q       <= 1'b0;
          instr_done_q <= 1'b0;
          halted_q     <= 1'b0;
          state_q      <= ST_RST;
        end
      endcase
    end
  end

  // Strobes are registered but masked while the clock enable is low so a frozen cycle never repeats them.
  assign mc.o_MCROM_READ_TICK = tick_q & i_CEN;
  assign o_MC_EXEC            = exec_q & i_CEN;
  assign o_INSTR_DONE         = instr_done_q & i_CEN;
  assign mc.o_MCROM_ADDR      = addr_q;
  assign mc.o_BUS_REQ         = bus_req_q;
  assign mc.o_BUS_TYPE        = bus_type_q;
  assign o_STEP               = step_q;
  assign o_HALTED             = halted_q;
  assign o_FAULT              = fault_q;

endmodule

// File: tb/tb_ika87ad_mcseq.sv
// Bench for ika87ad_mcseq: directed latency/halt/fault scenarios, then randomized microcode
// checked against a per-instruction event model (ticks and data bus cycles).
module tb_ika87ad_mcseq;
  localparam int MAXS = 8;

  logic       clk = 1'b0;
  logic       rst, cen, halt;
  logic [7:0] entry;
  logic       mc_exec, instr_done, halted, fault;
  logic [2:0] step;

  ika87ad_mcseq_if #(.ADDR_W(8)) mif ();

  ika87ad_mcseq #(.MAX_STEPS(MAXS), .ADDR_W(8)) dut (
    .i_CLK(clk), .i_RST(rst), .i_CEN(cen), .i_ENTRY_ADDR(entry), .mc(mif),
    .o_MC_EXEC(mc_exec), .o_STEP(step), .o_INSTR_DONE(instr_done),
    .i_HALT(halt), .o_HALTED(halted), .o_FAULT(fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [17:0] rom [256];
  logic [17:0] rom_q = 18'd0;
  int          bus_lat;
  logic        mon_on;

  // registered microcode ROM
  always @(posedge clk) if (mif.o_MCROM_READ_TICK) rom_q <= rom[mif.o_MCROM_ADDR];
  assign mif.i_MCROM_DATA = rom_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // bus slave: completes each request after bus_lat cycles, holds done until an enabled edge takes it
  initial begin : bus_slave
    int   cnt;
    logic acc, rst_s;
    cnt = 0;
    mif.i_BUS_DONE = 1'b0;
    forever begin
      @(posedge clk);
      acc   = mif.i_BUS_DONE && cen;
      rst_s = rst;
      #1;
      if (rst_s) begin
        mif.i_BUS_DONE = 1'b0;
        cnt = 0;
      end else if (mif.i_BUS_DONE) begin
        if (acc) begin
          mif.i_BUS_DONE = 1'b0;
          cnt = 0;
        end
      end else if (mif.o_BUS_REQ) begin
        cnt++;
        if (cnt >= bus_lat) mif.i_BUS_DONE = 1'b1;
      end
    end
  end

  // ---------------- reference model (event level) ----------------
  logic [31:0] exp_q[$];
  logic        m_fault;
  int          fetch_cnt, exec_cnt, tick_cnt, idone_cnt;

  // event word: {kind[1:0], fault, bus type[1:0], step[3:0], addr[7:0]}
  task automatic model_instr(input logic [7:0] ent);
    logic [7:0] a;
    logic [3:0] s;
    logic [2:0] c;
    logic       f;
    a = ent;
    s = 4'd0;
    f = m_fault;
    for (int k = 0; k < MAXS; k++) begin
      exp_q.push_back({15'd0, 2'd1, f, 2'b00, s, a});
      c = rom[a][2:0];
      if (c == 3'd0 || c > 3'd3) begin
        if (c > 3'd3) m_fault = 1'b1;
        break;
      end
      if (k == MAXS - 1) begin
        m_fault = 1'b1;
        break;
      end
      if (c != 3'd3) exp_q.push_back({15'd0, 2'd2, f, (c == 3'd1) ? 2'b01 : 2'b10, s, a});
      a = a + 8'd1;
      s = s + 4'd1;
    end
  endtask

  // monitor: observes the cycle at negedge, where every input equals what the next edge will sample
  initial begin : monitor
    logic [31:0] obs;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (cen && mif.i_BUS_DONE && mif.o_BUS_REQ && mif.o_BUS_TYPE == 2'b00) begin
          chk("drain", 32'(exp_q.size()), 32'd0);
          chk("exec_vs_tick", 32'(exec_cnt), 32'(tick_cnt));
          chk("idone_cnt", 32'(idone_cnt), 32'(fetch_cnt));
          chk("fault_flag", {31'd0, fault}, {31'd0, m_fault});
          model_instr(entry);
          fetch_cnt++;
        end
        if (mif.o_MCROM_READ_TICK) begin
          tick_cnt++;
          obs = {15'd0, 2'd1, fault, 2'b00, 1'b0, step, mif.o_MCROM_ADDR};
          if (exp_q.size() == 0) chk("tick_unexpected", obs, 32'd0);
          else chk("tick_evt", obs, exp_q.pop_front());
        end
        if (cen && mif.i_BUS_DONE && mif.o_BUS_REQ && mif.o_BUS_TYPE != 2'b00) begin
          obs = {15'd0, 2'd2, fault, mif.o_BUS_TYPE, 1'b0, step, mif.o_MCROM_ADDR};
          if (exp_q.size() == 0) chk("bus_unexpected", obs, 32'd0);
          else chk("bus_evt", obs, exp_q.pop_front());
        end
        if (mc_exec) exec_cnt++;
        if (instr_done) idone_cnt++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] outs();
    return {mc_exec, instr_done, halted, fault, mif.o_MCROM_READ_TICK, mif.o_BUS_REQ,
            mif.o_BUS_TYPE, step, mif.o_MCROM_ADDR};
  endfunction

  function automatic logic ev(input int sel);
    case (sel)
      0: return mif.o_MCROM_READ_TICK;
      1: return mc_exec;
      2: return mif.o_BUS_REQ && mif.o_BUS_TYPE == 2'b00;
      3: return mif.o_BUS_REQ && mif.o_BUS_TYPE == 2'b01;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_ev(input string tag, input int sel);
    int n;
    n = 0;
    while (!ev(sel) && n < 200) begin
      nxt();
      n++;
    end
    chk(tag, {31'd0, (n < 200)}, 32'd1);
  endtask

  task automatic rand_round(input logic heavy3);
    int         r, n;
    logic [2:0] code;
    logic [14:0] hi;
    rst = 1'b1; mon_on = 1'b0; cen = 1'b1; halt = 1'b0;
    nxt(); nxt();
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 99);
      if (heavy3) code = (r < 10) ? 3'd0 : (r < 15) ? 3'd1 : (r < 20) ? 3'd2 : (r < 98) ? 3'd3 : 3'(4 + r % 4);
      else        code = (r < 25) ? 3'd0 : (r < 45) ? 3'd1 : (r < 65) ? 3'd2 : (r < 95) ? 3'd3 : 3'(4 + r % 4);
      hi = 15'($urandom);
      rom[i] = {hi, code};
    end
    exp_q.delete();
    m_fault = 1'b0;
    fetch_cnt = 0; exec_cnt = 0; tick_cnt = 0; idone_cnt = 0;
    rst = 1'b0;
    mon_on = 1'b1;
    n = 0;
    while (fetch_cnt < 60 && n < 8000) begin
      cen     = ($urandom_range(0, 4) != 0);
      entry   = 8'($urandom_range(0, 255));
      bus_lat = $urandom_range(1, 3);
      nxt();
      n++;
    end
    chk("rand_progress", {31'd0, (fetch_cnt >= 60)}, 32'd1);
    mon_on = 1'b0;
    cen = 1'b1;
  endtask

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int cnt, n;
    rst = 1'b1; cen = 1'b1; halt = 1'b0; entry = 8'h00; bus_lat = 1; mon_on = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 18'd0;

    // reset
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("rst_outs", 32'(outs()), 32'd0);
    end
    entry = 8'h40;
    rst = 1'b0;
    nxt();
    chk("rst_fetch", {29'd0, mif.o_BUS_REQ, mif.o_BUS_TYPE}, 32'h4);

    // NOP: done taken at edge N
    nxt();
    chk("nop_tick", {18'd0, mif.o_MCROM_READ_TICK, instr_done, mif.o_BUS_REQ, mif.o_MCROM_ADDR, step},
        {18'd0, 1'b1, 1'b1, 1'b0, 8'h40, 3'd0});
    entry = 8'h10; bus_lat = 4;
    rom[8'h10] = 18'd1; rom[8'h11] = 18'd0;
    nxt();
    chk("nop_exec", {30'd0, mc_exec, mif.o_MCROM_READ_TICK}, 32'h2);
    nxt();
    chk("nop_fetch", {26'd0, mif.o_BUS_REQ, mif.o_BUS_TYPE, step}, {26'd0, 1'b1, 2'b00, 3'd0});

    // LDAX-like: data read held for 4 cycles
    wait_ev("ldax_wait", 3);
    cnt = 0;
    while (ev(3) && cnt < 50) begin
      cnt++;
      nxt();
    end
    chk("ldax_hold", 32'(cnt), 32'd4);
    chk("ldax_tick2", {20'd0, mif.o_MCROM_READ_TICK, mif.o_MCROM_ADDR, step}, {20'd0, 1'b1, 8'h11, 3'd1});
    nxt(); nxt();
    chk("ldax_fetch", {29'd0, mif.o_BUS_REQ, mif.o_BUS_TYPE}, 32'h4);

    // reserved code and address wrap
    rom[8'hFF] = 18'd3; rom[8'h00] = 18'd5;
    entry = 8'hFF; bus_lat = 1;
    wait_ev("wrap_wait", 0);
    chk("wrap_t1", {20'd0, fault, mif.o_MCROM_ADDR, step}, {20'd0, 1'b0, 8'hFF, 3'd0});
    nxt(); nxt();
    chk("wrap_t2", {20'd0, mif.o_MCROM_READ_TICK, mif.o_MCROM_ADDR, step}, {20'd0, 1'b1, 8'h00, 3'd1});
    nxt(); nxt();
    chk("rsvd_fault", {28'd0, mif.o_BUS_REQ, mif.o_BUS_TYPE, fault}, {28'd0, 1'b1, 2'b00, 1'b1});

    // reset clears the sticky fault
    rst = 1'b1;
    nxt(); nxt();
    chk("rst2_outs", 32'(outs()), 32'd0);
    for (int i = 8'h20; i < 8'h30; i++) rom[i] = 18'd3;
    entry = 8'h20;
    rst = 1'b0;

    // step overflow: exactly MAXS exec pulses then fault and back to fetch
    wait_ev("ovf_wait", 0);
    cnt = 0; n = 0;
    while (!ev(2) && n < 100) begin
      if (mc_exec) cnt++;
      nxt();
      n++;
    end
    chk("ovf_execs", 32'(cnt), 32'(MAXS));
    chk("ovf_fault", {31'd0, fault}, 32'd1);
    entry = 8'h40;
    wait_ev("ovf_wait2", 0);
    wait_ev("ovf_wait3", 2);
    chk("ovf_sticky", {31'd0, fault}, 32'd1);

    // halt and clock enable
    rom[8'h50] = 18'd3; rom[8'h51] = 18'd0;
    entry = 8'h50; halt = 1'b1;
    wait_ev("halt_wait", 0);
    chk("halt_t1", {20'd0, halted, mif.o_MCROM_ADDR, step}, {20'd0, 1'b0, 8'h50, 3'd0});
    cen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("cen_freeze", {19'd0, mif.o_MCROM_READ_TICK, mc_exec, instr_done, mif.o_MCROM_ADDR, step},
          {19'd0, 3'b000, 8'h50, 3'd0});
    end
    cen = 1'b1;
    #1;
    chk("cen_resume", {31'd0, mif.o_MCROM_READ_TICK}, 32'd1);
    nxt(); nxt();
    chk("halt_t2", {19'd0, mif.o_MCROM_READ_TICK, halted, mif.o_MCROM_ADDR, step}, {19'd0, 1'b1, 1'b0, 8'h51, 3'd1});
    nxt();
    chk("halt_exec", {30'd0, mc_exec, halted}, 32'h2);
    nxt();
    chk("halted", {30'd0, halted, mif.o_BUS_REQ}, 32'h2);
    nxt(); nxt();
    chk("halted_hold", {30'd0, halted, mif.o_BUS_REQ}, 32'h2);
    halt = 1'b0;
    nxt();
    chk("halt_exit", {29'd0, halted, mif.o_BUS_REQ, mif.o_BUS_TYPE[0]}, 32'h2);

    // reset in the middle of a data bus cycle
    rom[8'h60] = 18'd1;
    entry = 8'h60; bus_lat = 20;
    wait_ev("mid_wait", 3);
    nxt(); nxt();
    rst = 1'b1;
    nxt();
    chk("mid_rst", 32'(outs()), 32'd0);
    rst = 1'b0; bus_lat = 1;

    // randomized microcode against the event model
    rand_round(1'b0);
    rand_round(1'b1);
    rand_round(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ika87ad_mcseq.md
Name: ika87ad_mcseq

Overview:
Microcode sequencer for the IKA87AD core. Drives the microcode ROM's address and read-tick inputs and consumes its registered 18-bit microword. Walks each instruction's microsteps and issues one bus cycle per step, as encoded in the microword's low 3 bits. Returns to opcode fetch at the end of every instruction and provides halt and fault handling at instruction boundaries.

Parameters:
MAX_STEPS, 8, maximum microsteps per instruction before a forced abort (power of two, 2..16).
ADDR_W, 8, microcode ROM address width.

Ports:
i_CLK  in  1  core clock
i_RST  in  1  synchronous, active-high reset
i_CEN  in  1  clock enable; the state machine advances only when i_CEN=1
i_ENTRY_ADDR  in  ADDR_W  ROM entry address from the opcode decoder; valid on the cycle the opcode fetch completes
o_MCROM_READ_TICK  out  1  one-cycle ROM read strobe
o_MCROM_ADDR  out  ADDR_W  ROM address; held stable while the tick is high
i_MCROM_DATA  in  18  microword, valid the cycle after the tick
o_MC_EXEC  out  1  one-cycle strobe: the microword is valid and the datapath acts on it
o_BUS_REQ  out  1  bus cycle request; level signal, held until i_BUS_DONE
o_BUS_TYPE  out  2  00 opcode fetch (RD4), 01 data read (RD3), 10 data write (WR3)
i_BUS_DONE  in  1  bus cycle complete (one-cycle pulse)
o_STEP  out  log2(MAX_STEPS)  current microstep index
o_INSTR_DONE  out  1  one-cycle pulse when an opcode fetch completes
i_HALT  in  1  halt request, sampled at instruction boundaries
o_HALTED  out  1  core is halted
o_FAULT  out  1  sticky error flag; cleared only by reset

Behaviour:
- Next-action code: i_MCROM_DATA[2:0].
  - 0 = RD4: end the instruction and fetch the next opcode.
  - 1 = RD3: data read, then go to the next step.
  - 2 = WR3: data write, then go to the next step.
  - 3 = internal: no bus cycle, go to the next step.
  - 4..7 are reserved. They are treated as RD4 and set o_FAULT.
- States: RST, FETCH, TICK, EXEC, BUS, HALT.
- Every transition, and every strobe, is qualified by i_CEN. When i_CEN=0 the state holds and all strobes are 0.
- Reset (i_RST=1): state=RST. o_MCROM_ADDR=0, o_STEP=0, o_BUS_TYPE=00. All other outputs are 0, including o_FAULT. Reset applied mid-bus-cycle abandons the cycle and drops o_BUS_REQ on the next edge.
- RST -> FETCH on the first enabled cycle after reset deasserts.
- FETCH:
  - Drives o_BUS_REQ=1 and o_BUS_TYPE=00.
  - On i_BUS_DONE: latch i_ENTRY_ADDR into o_MCROM_ADDR, set o_STEP=0, pulse o_INSTR_DONE, go to TICK.
- TICK: o_MCROM_READ_TICK=1 for exactly one enabled cycle, then go to EXEC.
- EXEC:
  - o_MC_EXEC=1 for one cycle. Decode the code.
  - Bus codes (RD3/WR3) -> BUS.
  - Code 3 -> increment o_MCROM_ADDR and o_STEP, go to TICK.
  - RD4 (or reserved code) -> HALT if i_HALT=1, else FETCH.
- BUS:
  - Holds o_BUS_REQ=1 with the type latched in EXEC.
  - On i_BUS_DONE: increment o_MCROM_ADDR (wraps modulo 2^ADDR_W) and o_STEP, go to TICK.
- Step limit: if EXEC decodes a non-RD4 code while o_STEP = MAX_STEPS-1:
  - set o_FAULT,
  - suppress the bus cycle,
  - go to FETCH (or HALT if i_HALT=1).
- HALT: o_HALTED=1. o_BUS_REQ=0. Exit to FETCH on the first enabled cycle with i_HALT=0. o_HALTED clears on that same edge.
- i_HALT is ignored except at the RD4 decision and in HALT.
- i_BUS_DONE arriving outside FETCH/BUS is ignored.
- Latency (i_CEN=1, bus done at edge N): tick at N+1, exec at N+2, bus request at N+3.
  - An internal step costs 2 cycles (TICK + EXEC).
  - Minimum instruction (fetch-done to fetch-request) costs 3 cycles.

Test Plan:
- Reset: hold i_RST for 3 cycles, then release -> all outputs 0 during reset; o_BUS_REQ=1 with o_BUS_TYPE=00 one cycle after release.
- NOP flow: entry=0x40, ROM returns code 0 -> tick at addr 0x40 at N+1, o_MC_EXEC at N+2, fetch request at N+3, o_STEP=0.
- LDAX-like flow: entry=0x10, step 0 code 1, step 1 code 0; delay i_BUS_DONE by 4 cycles -> o_BUS_TYPE=01 held for 4 cycles; second tick at 0x11 with o_STEP=1; then fetch.
- Step overflow: ROM always returns code 3 with MAX_STEPS=8 -> exactly 8 exec pulses, o_FAULT=1, return to FETCH; o_FAULT stays 1 until reset.
- Halt and clock-enable: i_HALT=1 during a 2-step instruction -> o_HALTED only after the RD4 exec; drop i_HALT -> fetch resumes next cycle. Toggling i_CEN=0 mid-instruction freezes state and strobes.
- Reserved code and wrap: entry=0xFF with code 3, then code 5 -> second tick at addr 0x00; code 5 sets o_FAULT and returns to fetch.
